ram_1p_burst_ctrl: RTL and testbench

RAM_1P_BURST_CTRL -- requirements
Module: ram_1p_burst_ctrl

---
 rtl/ram_1p_burst_ctrl.sv | 105 ++++++++++
 tb/tb_ram_1p_burst_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_1p_burst_ctrl.sv
// ram_1p_burst_ctrl: burst read/write controller for a single-port RAM with one-cycle read latency.
module ram_1p_burst_ctrl #(
  parameter int Word_Width = 32,
  parameter int Addr_Width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [Addr_Width-1:0] cmd_addr_i,
  input  logic [Addr_Width-1:0] cmd_len_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  input  logic [Word_Width-1:0] wdata_i,
  output logic                  rdata_valid_o,
  input  logic                  rdata_ready_i,
  output logic [Word_Width-1:0] rdata_o,
  output logic                  done_o,
  output logic                  ram_cen_o,
  output logic                  ram_wen_o,
  output logic                  ram_oen_o,
  output logic [Addr_Width-1:0] ram_addr_o,
  output logic [Word_Width-1:0] ram_data_o,
  input  logic [Word_Width-1:0] ram_data_i
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  localparam logic [Addr_Width-1:0] addr_one = 1;
  localparam logic [Addr_Width:0]   cnt_one  = 1;
  state_t                state, state_nx;
  logic [Addr_Width-1:0] addr, addr_q;
  logic [Word_Width-1:0] data_q;
  logic [Addr_Width:0]   issue_left, pop_left;
  logic                  inflight, wr_ptr, rd_ptr, done_q;
  logic [1:0]            cnt;
  logic [Word_Width-1:0] fifo [2];
  logic                  wr_beat, rd_issue, access, pop;
  // A read may only go out while the FIFO can still absorb everything outstanding.
  always_comb begin
    wr_beat       = (state == WRITE) && wdata_valid_i;
    rd_issue      = (state == READ) && (({1'b0, cnt} + {2'b0, inflight}) < 3'd2);
    access        = wr_beat || rd_issue;
    rdata_valid_o = cnt != 2'd0;
    pop           = rdata_valid_o && rdata_ready_i;
    rdata_o       = fifo[rd_ptr];
    cmd_ready_o   = state == IDLE;
    wdata_ready_o = state == WRITE;
    done_o        = done_q;
    ram_cen_o     = !access;
    ram_wen_o     = !wr_beat;
    ram_oen_o     = !((state == READ) || (state == DRAIN));
    ram_addr_o    = access ? addr : addr_q;
    ram_data_o    = wr_beat ? wdata_i : data_q;
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = cmd_valid_i ? (cmd_wr_i ? WRITE : READ) : IDLE;
      WRITE: state_nx = (wr_beat && issue_left == cnt_one) ? IDLE : WRITE;
      READ:  state_nx = (rd_issue && issue_left == cnt_one) ? DRAIN : READ;
      DRAIN: state_nx = (pop && pop_left == cnt_one) ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      done_q     <= 1'b0;
      addr       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      issue_left <= '0;
      pop_left   <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      cnt        <= 2'd0;
      fifo[0]    <= '0;
      fifo[1]    <= '0;
    end else begin
      state    <= state_nx;
      done_q   <= (state != IDLE) && (state_nx == IDLE);
      inflight <= rd_issue;
      cnt      <= cnt + {1'b0, inflight} - {1'b0, pop};
      if (state == IDLE && cmd_valid_i) begin
        addr       <= cmd_addr_i;
        issue_left <= {1'b0, cmd_len_i} + cnt_one;
        pop_left   <= {1'b0, cmd_len_i} + cnt_one;
      end
      if (access) begin
        addr       <= addr + addr_one;
        addr_q     <= addr;
        issue_left <= issue_left - cnt_one;
      end
      if (wr_beat) data_q <= wdata_i;
      if (inflight) begin
        fifo[wr_ptr] <= ram_data_i;
        wr_ptr       <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr   <= !rd_ptr;
        pop_left <= pop_left - cnt_one;
      end
    end
  end
endmodule

// File: tb/tb_ram_1p_burst_ctrl.sv
// tb_ram_1p_burst_ctrl: directed bursts against a bench RAM, checked every cycle by a scoreboard model.
module tb_ram_1p_burst_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid_i, cmd_ready_o, cmd_wr_i;
  logic [7:0]  cmd_addr_i, cmd_len_i;
  logic        wdata_valid_i, wdata_ready_o, rdata_valid_o, rdata_ready_i, done_o;
  logic [31:0] wdata_i, rdata_o;
  logic        ram_cen_o, ram_wen_o, ram_oen_o;
  logic [7:0]  ram_addr_o;
  logic [31:0] ram_data_o, ram_data_i;
  always #5 clk = ~clk;
  ram_1p_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
    .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i), .rdata_o(rdata_o),
    .done_o(done_o), .ram_cen_o(ram_cen_o), .ram_wen_o(ram_wen_o), .ram_oen_o(ram_oen_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );
  function automatic logic [31:0] init_word(input logic [7:0] a);
    return 32'hD000_0000 | {24'h0, a};
  endfunction
  // Synchronous single-port RAM, one-cycle read latency; unwritten words read as init_word.
  logic [31:0] ram [256];
  bit   [255:0] written;
  logic [31:0] ram_rd;
  assign ram_data_i = ram_rd;
  always @(posedge clk)
    if (!ram_cen_o) begin
      if (!ram_wen_o) begin
        ram[ram_addr_o]     <= ram_data_o;
        written[ram_addr_o] <= 1'b1;
      end else ram_rd <= written[ram_addr_o] ? ram[ram_addr_o] : init_word(ram_addr_o);
    end
  function automatic logic [31:0] mem_word(input int a);
    return written[a[7:0]] ? ram[a[7:0]] : init_word(a[7:0]);
  endfunction
  typedef struct {logic [7:0] a; logic [31:0] d;} wr_t;
  logic [31:0] ref_mem [256];
  wr_t         wq[$];
  logic [31:0] rq[$];
  bit          wr_active, rd_active, done_due;
  int          issued, popped, strobes, errors = 0, checks = 0;
  logic [31:0] last_pop;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask
  // Scoreboard: every write strobe, read issue and pop must match what the burst rules allow.
  always @(negedge clk) begin
    bit  ended;
    wr_t e;
    ended = 1'b0;
    if (!rst_n) begin
      wq.delete();
      rq.delete();
      wr_active = 1'b0;
      rd_active = 1'b0;
      done_due  = 1'b0;
      issued    = 0;
      popped    = 0;
    end else begin
      chk1("done", done_o, done_due);
      chk1("cmd_ready", cmd_ready_o, !(wr_active || rd_active));
      chk1("oen", ram_oen_o, !rd_active);
      chk1("wr_strobe", !ram_cen_o && !ram_wen_o, wr_active && wdata_valid_i);
      if (!ram_cen_o && !ram_wen_o && wq.size() > 0) begin
        e = wq.pop_front();
        strobes++;
        chk("wr_addr", {24'h0, ram_addr_o}, {24'h0, e.a});
        chk("wr_data", ram_data_o, e.d);
        if (wq.size() == 0) begin
          wr_active = 1'b0;
          ended     = 1'b1;
        end
      end
      if (!ram_cen_o && ram_wen_o) begin
        chk1("rd_issue_in_burst", rd_active, 1'b1);
        issued++;
      end
      if (rdata_valid_o && rdata_ready_i) begin
        popped++;
        last_pop = rdata_o;
        chk1("pop_in_burst", rd_active, 1'b1);
        if (rq.size() > 0) begin
          chk("rdata", rdata_o, rq.pop_front());
          if (rq.size() == 0) begin
            rd_active = 1'b0;
            ended     = 1'b1;
          end
        end
      end
      checks++;
      assert (issued - popped <= 2) else begin
        errors++;
        $display("FAIL outstanding: got %0d expected at most 2", issued - popped);
      end
      done_due = ended;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_cmd(input bit wr, input logic [7:0] a, input logic [7:0] len);
    cmd_valid_i = 1'b1;
    cmd_wr_i    = wr;
    cmd_addr_i  = a;
    cmd_len_i   = len;
    @(negedge clk);
    chk1("cmd_accept_ready", cmd_ready_o, 1'b1);
    step();
    cmd_valid_i = 1'b0;
    if (wr) wr_active = 1'b1;
    else begin
      rd_active = 1'b1;
      for (int i = 0; i <= int'(len); i++) rq.push_back(ref_mem[8'(a + i)]);
    end
  endtask
  task automatic do_write(input logic [7:0] a, input logic [7:0] len, input logic [31:0] base,
                          input logic [15:0] pat, input bit extra);
    int i, k;
    i = 0;
    k = 0;
    send_cmd(1'b1, a, len);
    for (int j = 0; j <= int'(len); j++) begin
      wq.push_back('{8'(a + j), base + j});
      ref_mem[8'(a + j)] = base + j;
    end
    if (extra) begin
      cmd_valid_i = 1'b1;
      cmd_wr_i    = 1'b0;
      cmd_addr_i  = 8'h77;
      cmd_len_i   = 8'h05;
    end
    while (i <= int'(len) && k < 64) begin
      wdata_valid_i = pat[k % 16];
      wdata_i       = base + i;
      step();
      if (wdata_valid_i) i++;
      k++;
    end
    wdata_valid_i = 1'b0;
    cmd_valid_i   = 1'b0;
  endtask
  task automatic wait_done(input int max);
    int n;
    n = 0;
    while ((wr_active || rd_active) && n < max) begin
      step();
      n++;
    end
    chk1("burst_finish_in_time", wr_active || rd_active, 1'b0);
  endtask
  task automatic check_reset_outputs();
    chk1("rst_cmd_ready", cmd_ready_o, 1'b1);
    chk1("rst_wdata_ready", wdata_ready_o, 1'b0);
    chk1("rst_rdata_valid", rdata_valid_o, 1'b0);
    chk1("rst_done", done_o, 1'b0);
    chk1("rst_cen", ram_cen_o, 1'b1);
    chk1("rst_wen", ram_wen_o, 1'b1);
    chk1("rst_oen", ram_oen_o, 1'b1);
    chk("rst_addr", {24'h0, ram_addr_o}, 32'h0);
    chk("rst_wdata", ram_data_o, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int s0, p0, n;
    cmd_valid_i   = 1'b0;
    cmd_wr_i      = 1'b0;
    cmd_addr_i    = 8'h0;
    cmd_len_i     = 8'h0;
    wdata_valid_i = 1'b0;
    wdata_i       = 32'h0;
    rdata_ready_i = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    step();
    rst_n = 1'b1;
    step();
    do_write(8'h10, 8'd3, 32'hA0, 16'hFFFF, 1'b0);
    @(negedge clk);
    chk1("t1_done_after_last_beat", done_o, 1'b1);
    for (int i = 0; i < 4; i++) chk("t1_ram", mem_word(8'h10 + i), 32'hA0 + i);
    step();
    rdata_ready_i = 1'b1;
    send_cmd(1'b0, 8'h10, 8'd3);
    @(negedge clk);
    @(negedge clk);
    chk1("t2_valid_not_yet", rdata_valid_o, 1'b0);
    @(negedge clk);
    chk1("t2_first_valid", rdata_valid_o, 1'b1);
    chk("t2_first_data", rdata_o, 32'hA0);
    wait_done(50);
    s0 = strobes;
    do_write(8'h14, 8'd3, 32'hB0, 16'h0059, 1'b1);
    chk("t3_write_count", strobes - s0, 32'd4);
    repeat (3) step();
    chk("t3_model_pin", ref_mem[8'h14], 32'hB0);
    send_cmd(1'b0, 8'h10, 8'd7);
    n = 0;
    while (rd_active && n < 300) begin
      rdata_ready_i = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk1("t4_finished", rd_active, 1'b0);
    rdata_ready_i = 1'b1;
    step();
    do_write(8'hFE, 8'd3, 32'hC0, 16'hFFFF, 1'b0);
    step();
    chk("t5_ram_fe", mem_word(8'hFE), 32'hC0);
    chk("t5_ram_ff", mem_word(8'hFF), 32'hC1);
    chk("t5_ram_00", mem_word(8'h00), 32'hC2);
    chk("t5_ram_01", mem_word(8'h01), 32'hC3);
    p0 = popped;
    send_cmd(1'b0, 8'h00, 8'd15);
    n = 0;
    while (popped - p0 < 5 && n < 100) begin
      step();
      n++;
    end
    chk1("t6_reached_beat5", popped - p0 >= 5, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    step();
    rst_n = 1'b1;
    step();
    chk("t6_model_pin", ref_mem[8'h00], 32'hC2);
    send_cmd(1'b0, 8'h00, 8'd0);
    wait_done(20);
    chk("t6_fresh_data", last_pop, 32'hC2);
    step();
    p0 = popped;
    send_cmd(1'b0, 8'h80, 8'hFF);
    wait_done(1000);
    chk("t7_full_wrap_beats", popped - p0, 32'd256);
    step();
    step();
    chk("queues_empty", wq.size() + rq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
